// File: rtl/blc_line_feeder.sv
// ============================================================================
//  blc_line_feeder : captures source pixels into a two-bank ping-pong line
//  store and bursts each complete line to the BLC stage. Optional test
//  pattern source enabled by defining FEEDER_TPG_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module blc_line_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int BPN_L      = 100,
  parameter int READ_PIXEL = 16,
  parameter int BPN_R      = 100,
  parameter int LINE_LEN   = BPN_L + READ_PIXEL + BPN_R + 2,
  parameter int TIMEOUT    = 1024,
  parameter int TPG_BLACK  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_sol,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  blc_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  line_drop,
`ifdef FEEDER_TPG_EN
  input  logic                  tpg_en,
`endif
  output logic                  ack_tmo
);

  localparam int AW = $clog2(2 * LINE_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, PREFETCH, BURST, WAIT_ACK} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [0:2*LINE_LEN-1];
  logic [15:0]           wr_cnt, rd_cnt, wr_idx, rd_idx_nxt;
  logic                  wr_bank, rd_bank, tpg_mode, seen_low;
  logic [1:0]            full, set_mask, clr_mask;
  logic [TW-1:0]         tmo_cnt;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] pix_nxt;
  logic                  accept, do_write, wr_last, tpg_req;
  logic                  burst_end, tmo_fire, load_data;

  // ---------------- ingress ----------------
  assign s_ready  = !(full[0] && full[1]);
  assign accept   = s_valid && s_ready;
  // A beat without start-of-line at index 0 is dropped while hunting for a line start.
  assign do_write = accept && (s_sol || (wr_cnt != 16'd0));
  assign wr_idx   = s_sol ? 16'd0 : wr_cnt;
  assign wr_last  = accept && !s_sol && (wr_cnt == 16'(LINE_LEN - 1));
  assign wr_addr  = AW'(wr_idx) + (wr_bank ? AW'(LINE_LEN) : AW'(0));
  assign set_mask = wr_last ? (2'b01 << wr_bank) : 2'b00;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_addr] <= s_data;
  end

  // ---------------- read side ----------------
`ifdef FEEDER_TPG_EN
  assign tpg_req = tpg_en;

  function automatic logic [DATA_WIDTH-1:0] tpg_pix(input logic [15:0] idx);
    int i;
    i = int'(idx);
    if (i == 0 || i == LINE_LEN - 1)                 return '0;
    else if (i >= BPN_L + 1 && i <= BPN_L + READ_PIXEL)
      return DATA_WIDTH'(TPG_BLACK + 4 * (i - BPN_L - 1));
    else                                             return DATA_WIDTH'(TPG_BLACK);
  endfunction

  assign pix_nxt = tpg_mode ? tpg_pix(rd_idx_nxt) : mem[rd_addr];
`else
  assign tpg_req = 1'b0;
  assign pix_nxt = mem[rd_addr];
`endif

  assign rd_idx_nxt = (state == PREFETCH) ? 16'd0 : rd_cnt + 16'd1;
  assign rd_addr    = AW'(rd_idx_nxt) + (rd_bank ? AW'(LINE_LEN) : AW'(0));
  assign clr_mask   = (burst_end && !tpg_mode) ? (2'b01 << rd_bank) : 2'b00;
  assign load_data  = (state == PREFETCH) || (state == BURST && !burst_end);
  assign m_valid    = (state == BURST);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    burst_end = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      IDLE:     if (blc_ready && (tpg_req || full[rd_bank])) state_nxt = PREFETCH;
      PREFETCH: state_nxt = BURST;
      BURST: begin
        if (rd_cnt == 16'(LINE_LEN - 1)) begin
          burst_end = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // BLC readout is complete once ready has been seen low and then high again.
        if (seen_low && blc_ready) begin
          state_nxt = IDLE;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          tmo_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      full      <= 2'b00;
      wr_cnt    <= 16'd0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      rd_cnt    <= 16'd0;
      tpg_mode  <= 1'b0;
      seen_low  <= 1'b0;
      tmo_cnt   <= '0;
      m_data    <= '0;
      line_drop <= 1'b0;
      ack_tmo   <= 1'b0;
    end else begin
      state     <= state_nxt;
      // Set and clear always target different banks, so both apply.
      full      <= (full | set_mask) & ~clr_mask;
      line_drop <= accept && s_sol && (wr_cnt != 16'd0);
      ack_tmo   <= tmo_fire;

      if (wr_last) begin
        wr_cnt  <= 16'd0;
        wr_bank <= ~wr_bank;
      end else if (do_write) begin
        wr_cnt  <= wr_idx + 16'd1;
      end

      if (state == IDLE && state_nxt == PREFETCH) tpg_mode <= tpg_req;
      if (burst_end && !tpg_mode) rd_bank <= ~rd_bank;

      if (load_data) begin
        rd_cnt <= rd_idx_nxt;
        m_data <= pix_nxt;
      end

      if (state == WAIT_ACK) begin
        seen_low <= seen_low || !blc_ready;
        tmo_cnt  <= tmo_cnt + TW'(1);
      end else begin
        seen_low <= 1'b0;
        tmo_cnt  <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_blc_line_feeder.sv
// ============================================================================
//  tb_blc_line_feeder : randomized scoreboard bench for blc_line_feeder.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_blc_line_feeder;

  localparam int LINE_LEN = 218;
  localparam int TIMEOUT  = 1024;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       s_valid = 1'b0, s_sol = 1'b0, blc_ready = 1'b1;
  logic [7:0] s_data = 8'd0;
  logic       s_ready, m_valid, busy, line_drop, ack_tmo;
  logic [7:0] m_data;
`ifdef FEEDER_TPG_EN
  logic       tpg_en = 1'b0;
`endif

  blc_line_feeder dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_sol(s_sol),
    .s_data(s_data), .blc_ready(blc_ready), .m_valid(m_valid), .m_data(m_data),
    .busy(busy), .line_drop(line_drop),
`ifdef FEEDER_TPG_EN
    .tpg_en(tpg_en),
`endif
    .ack_tmo(ack_tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] part[$];
  int exp_drops = 0, got_drops = 0, got_tmo = 0;
  int run = 0, start_cyc = 0, end_cyc = 0, last_gap = 0, total_beats = 0;
  int full_cyc = 0, accepted = 0;
  bit in_reset = 1'b0;
  int blc_mode = 0;  // 0: respond like BLC, 1: held high, 2: held low

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  // Reference line assembly: a line is whatever follows a start-of-line beat,
  // and it becomes expected output once LINE_LEN pixels have been collected.
  task automatic model_accept(input logic [7:0] d, input bit sol);
    accepted++;
    if (sol) begin
      if (part.size() != 0) exp_drops++;
      part.delete();
      part.push_back(d);
    end else if (part.size() != 0) begin
      part.push_back(d);
      if (part.size() == LINE_LEN) begin
        foreach (part[k]) exp_q.push_back(part[k]);
        part.delete();
        full_cyc = cyc;
      end
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input bit sol);
    bit rdy;
    int n = 0;
    s_valid = 1'b1; s_data = d; s_sol = sol;
    do begin
      @(negedge clk); rdy = s_ready;
      @(posedge clk); n++;
    end while (!rdy && n < 20000);
    #1;
    if (!rdy) check("send_timeout", 0, 1);
    else      model_accept(d, sol);
    s_valid = 1'b0; s_sol = 1'b0;
  endtask

  function automatic logic [7:0] t1_pix(input int i);
    if (i == 0 || i == LINE_LEN - 1) return 8'd0;
    if (i >= 101 && i <= 116)        return 8'(100 + i - 101);
    return 8'd20;
  endfunction

  task automatic send_line(input bit fixed, input bit gaps);
    for (int i = 0; i < LINE_LEN; i++) begin
      send_beat(fixed ? t1_pix(i) : 8'($urandom), i == 0);
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_run(input bit active, input int limit, input string name);
    int n = 0;
    while (((run != 0) != active) && n < limit) begin @(posedge clk); #1; n++; end
    if (n >= limit) check(name, 0, 1);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || busy || run != 0) && n < limit) begin
      @(posedge clk); #1; n++;
    end
    check("drain_done", int'(n < limit), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (in_reset) begin
      run = 0;
    end else begin
      if (line_drop) got_drops++;
      if (ack_tmo)   got_tmo++;
      if (m_valid) begin
        if (run == 0) begin start_cyc = cyc; last_gap = cyc - end_cyc; end
        run++;
        total_beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got %0d required no beat", m_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL beat_data idx %0d got %0d required %0d", run - 1, m_data, e);
          end
        end
      end else if (run != 0) begin
        check("burst_len", run, LINE_LEN);
        end_cyc = cyc - 1;
        run = 0;
      end
    end
  end

  // BLC behaviour: after each burst, ready drops for a while (readout), then returns.
  initial begin
    int lowcnt = 0;
    bit prev_mv = 1'b0;
    forever begin
      @(negedge clk);
      if (blc_mode == 1)      blc_ready = 1'b1;
      else if (blc_mode == 2) blc_ready = 1'b0;
      else begin
        if (prev_mv && !m_valid) lowcnt = $urandom_range(5, 40);
        if (lowcnt > 0) begin blc_ready = 1'b0; lowcnt--; end
        else blc_ready = 1'b1;
      end
      prev_mv = m_valid;
    end
  end

  initial begin
    int tmo0, drops0, acc0, beats0;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_line_drop", int'(line_drop), 0);
    check("rst_ack_tmo", int'(ack_tmo), 0);
    check("rst_m_data", int'(m_data), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // One fixed-pattern line; first beat two cycles after the bank fills
    send_line(1'b1, 1'b0);
    wait_run(1'b1, 50, "t1_start_timeout");
    check("t1_latency", start_cyc - full_cyc, 2);
    wait_drain(3000);

    // Two queued lines, BLC never acknowledges: WAIT_ACK runs TIMEOUT cycles,
    // followed by the IDLE decision and PREFETCH before the next first beat
    blc_mode = 1;
    tmo0 = got_tmo;
    fork
      begin send_line(1'b0, 1'b0); send_line(1'b0, 1'b0); end
    join_none
    wait_run(1'b1, 3000, "t2_start1_timeout");
    wait_run(1'b0, 3000, "t2_end1_timeout");
    wait_run(1'b1, 3000, "t2_start2_timeout");
    check("t2_gap", last_gap, TIMEOUT + 3);
    check("t2_tmo_between", got_tmo - tmo0, 1);
    wait fork;
    wait_drain(6000);
    blc_mode = 0;

    // Restart mid-line at wr_cnt 50
    drops0 = got_drops;
    for (int i = 0; i < 50; i++) send_beat(8'($urandom), i == 0);
    send_line(1'b0, 1'b1);
    wait_drain(3000);
    check("t3_line_drop", got_drops - drops0, 1);

    // Backpressure: BLC busy, three lines streamed
    blc_mode = 2;
    acc0 = accepted;
    fork
      begin for (int l = 0; l < 3; l++) send_line(1'b0, 1'b0); end
    join_none
    begin
      int n = 0;
      while (accepted - acc0 < 2 * LINE_LEN && n < 3000) begin @(posedge clk); #1; n++; end
    end
    repeat (20) @(posedge clk);
    #1;
    check("t4_s_ready_low", int'(s_ready), 0);
    check("t4_accepted", accepted - acc0, 2 * LINE_LEN);
    blc_mode = 0;
    wait fork;
    wait_drain(8000);

    // Reset in the middle of a burst
    send_line(1'b0, 1'b0);
    begin
      int n = 0;
      while (run < 100 && n < 500) begin @(posedge clk); n++; end
      if (n >= 500) check("t5_burst_timeout", 0, 1);
    end
    #2;
    in_reset = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t5_m_valid_in_rst", int'(m_valid), 0);
    check("t5_busy_in_rst", int'(busy), 0);
    exp_q.delete();
    part.delete();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(negedge clk); #1; in_reset = 1'b0;
    check("t5_s_ready_after", int'(s_ready), 1);
    beats0 = total_beats;
    repeat (300) @(posedge clk);
    #1;
    check("t5_no_more_beats", total_beats - beats0, 0);

`ifdef FEEDER_TPG_EN
    // Test pattern: pads 0, black 16, active ramp of step 4
    for (int i = 0; i < LINE_LEN; i++) begin
      if (i == 0 || i == LINE_LEN - 1) exp_q.push_back(8'd0);
      else if (i >= 101 && i <= 116)   exp_q.push_back(8'(16 + 4 * (i - 101)));
      else                             exp_q.push_back(8'd16);
    end
    tpg_en = 1'b1;
    wait_run(1'b1, 100, "t6_start_timeout");
    tpg_en = 1'b0;
    wait_drain(3000);
`endif

    // Randomized traffic: junk before sync, restarts, idle gaps
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 5)) send_beat(8'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        int m;
        m = $urandom_range(1, LINE_LEN - 1);
        for (int i = 0; i < m; i++) send_beat(8'($urandom), i == 0);
      end
      send_line(1'b0, 1'b1);
    end
    wait_drain(10000);

    check("total_line_drops", got_drops, exp_drops);
    check("total_ack_tmo", got_tmo, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
